// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with ASCII step/address command parser
module uart_cmd_rx #(
  parameter int CLK_FREQ_HZ = 10000000,
  parameter int BAUD        = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rxd,
  input  logic       en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [6:0] debug_addr,
  output logic       addr_update,
  output logic       step_req,
  output logic       cmd_err
);

  localparam int CPB  = CLK_FREQ_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_H1, P_H2} p_state_t;

  logic          rx_meta, rxs;
  rx_state_t     rstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          brk;

  p_state_t      pstate;
  logic [3:0]    hi_nib;
  logic          is_hex;
  logic [3:0]    nib;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

  // Bit timing restarts on every start edge, so skew only accumulates within one frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rstate    <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      brk       <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (rstate)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (brk) begin
            if (rxs) brk <= 1'b0;
          end else if (!rxs) begin
            rstate <= START;
          end
        end
        START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt    <= '0;
            rstate <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rstate <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt    <= '0;
            rstate <= IDLE;
            if (rxs) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: rstate <= IDLE;
      endcase
    end
  end

  always_comb begin
    is_hex = 1'b0;
    nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0];
    end else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
                 (rx_data >= 8'h41 && rx_data <= 8'h46)) begin
      is_hex = 1'b1;
      nib    = rx_data[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pstate      <= P_IDLE;
      hi_nib      <= '0;
      debug_addr  <= '0;
      addr_update <= 1'b0;
      step_req    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      addr_update <= 1'b0;
      step_req    <= 1'b0;
      cmd_err     <= 1'b0;
      if (!en) begin
        pstate <= P_IDLE;
      end else if (rx_valid) begin
        case (pstate)
          P_IDLE: begin
            if (rx_data == 8'h73) step_req <= 1'b1;
            else if (rx_data == 8'h72) pstate <= P_H1;
            else if (rx_data != 8'h0D && rx_data != 8'h0A && rx_data != 8'h20)
              cmd_err <= 1'b1;
          end
          P_H1: begin
            if (is_hex) begin
              hi_nib <= nib;
              pstate <= P_H2;
            end else begin
              cmd_err <= 1'b1;
              pstate  <= P_IDLE;
            end
          end
          P_H2: begin
            pstate <= P_IDLE;
            // A set high bit means the value exceeds the 7-bit address range.
            if (is_hex && !hi_nib[3]) begin
              debug_addr  <= {hi_nib[2:0], nib};
              addr_update <= 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          default: pstate <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - directed self-checking bench for uart_cmd_rx
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int BT  = 86;
  localparam int BTF = 84;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, addr_update, step_req, cmd_err;
  logic [6:0] debug_addr;

  uart_cmd_rx dut (
    .clk(clk), .rstn(rstn), .uart_rxd(uart_rxd), .en(en),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .debug_addr(debug_addr), .addr_update(addr_update),
    .step_req(step_req), .cmd_err(cmd_err)
  );

  always #50 clk = ~clk;

  int tests = 0, fails = 0;
  int n_rxv = 0, n_step = 0, n_addr = 0, n_cmd = 0, n_ferr = 0;
  int lat_bad = 0, multi = 0;
  logic [7:0] rxq [0:63];
  int rxq_n = 0;
  logic prev_rxv = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rxv <= n_rxv + 1;
      if (rxq_n < 64) rxq[rxq_n] <= rx_data;
      rxq_n <= rxq_n + 1;
    end
    if (step_req) n_step <= n_step + 1;
    if (addr_update) n_addr <= n_addr + 1;
    if (cmd_err) n_cmd <= n_cmd + 1;
    if (frame_err) n_ferr <= n_ferr + 1;
    if ((step_req || addr_update || cmd_err) && !prev_rxv) lat_bad <= lat_bad + 1;
    if (int'(step_req) + int'(addr_update) + int'(cmd_err) > 1) multi <= multi + 1;
    prev_rxv <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int bt, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (bt) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (bt) @(posedge clk);
    end
    uart_rxd = stop_bit;
    repeat (bt) @(posedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], BT, 1'b1);
    repeat (10) @(posedge clk);
  endtask

  int b_rxv, b_step, b_addr, b_cmd, b_ferr, b_q;
  task automatic snap();
    #1;
    b_rxv = n_rxv; b_step = n_step; b_addr = n_addr; b_cmd = n_cmd; b_ferr = n_ferr; b_q = rxq_n;
  endtask

  logic [7:0] vec [0:15];

  initial begin
    vec = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'h3C,
            8'hC3, 8'h12, 8'h34, 8'hE7, 8'h0F, 8'hF0, 8'h99, 8'h66};
    repeat (5) @(posedge clk);
    #1;
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_debug_addr", debug_addr, 7'h00);
    check("rst_pulses", {rx_valid, frame_err, addr_update, step_req, cmd_err}, 5'b0);
    @(posedge clk);
    rstn = 1'b1;
    repeat (5) @(posedge clk);

    // Reset during bit 3 of 0x55
    uart_rxd = 1'b0;
    repeat (BT) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = 8'h55 >> i;
      repeat (BT) @(posedge clk);
    end
    uart_rxd = 1'b1;
    repeat (BT / 2) @(posedge clk);
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_outputs", {rx_valid, frame_err, addr_update, step_req, cmd_err}, 5'b0);
    check("midrst_debug_addr", debug_addr, 7'h00);
    rstn = 1'b1;
    repeat (BT) @(posedge clk);
    snap();
    send_str("\xA5");
    check("a5_rx_data", rx_data, 8'hA5);
    check("a5_rx_valid_cnt", n_rxv - b_rxv, 1);

    snap();
    send_str("s");
    check("step_rx_data", rx_data, 8'h73);
    check("step_cnt", n_step - b_step, 1);
    en = 1'b0;
    snap();
    send_str("s");
    check("step_en0_rxv", n_rxv - b_rxv, 1);
    check("step_en0_step", n_step - b_step, 0);
    en = 1'b1;

    snap();
    send_str("r1F\n");
    check("r1f_addr", debug_addr, 7'h1F);
    check("r1f_update", n_addr - b_addr, 1);
    check("r1f_cmd_err", n_cmd - b_cmd, 0);
    snap();
    send_str("rA0");
    check("ra0_cmd_err", n_cmd - b_cmd, 1);
    check("ra0_addr", debug_addr, 7'h1F);
    check("ra0_update", n_addr - b_addr, 0);
    snap();
    send_str("r7f");
    check("r7f_addr", debug_addr, 7'h7F);
    check("r7f_update", n_addr - b_addr, 1);

    snap();
    send_str("rG");
    send_str("x");
    send_str("r");
    en = 1'b0;
    repeat (5) @(posedge clk);
    en = 1'b1;
    repeat (5) @(posedge clk);
    check("malformed_cmd_err", n_cmd - b_cmd, 2);
    snap();
    send_str("s");
    check("after_en_drop_step", n_step - b_step, 1);
    check("after_en_drop_cmd", n_cmd - b_cmd, 0);

    snap();
    send_byte(8'h41, BT, 1'b0);
    repeat (3 * BT) @(posedge clk);
    uart_rxd = 1'b1;
    repeat (BT) @(posedge clk);
    #1;
    check("frame_err_cnt", n_ferr - b_ferr, 1);
    check("frame_err_rxv", n_rxv - b_rxv, 0);
    snap();
    send_str("s");
    check("after_break_step", n_step - b_step, 1);

    snap();
    uart_rxd = 1'b0;
    repeat (20) @(posedge clk);
    uart_rxd = 1'b1;
    repeat (2 * BT) @(posedge clk);
    #1;
    check("glitch_rxv", n_rxv - b_rxv, 0);
    check("glitch_ferr", n_ferr - b_ferr, 0);

    en = 1'b0;
    snap();
    for (int i = 0; i < 16; i++) send_byte(vec[i], BTF, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("b2b_count", n_rxv - b_rxv, 16);
    check("b2b_ferr", n_ferr - b_ferr, 0);
    for (int i = 0; i < 16; i++)
      if (b_q + i < 64) check($sformatf("b2b_byte%0d", i), rxq[b_q + i], vec[i]);
    en = 1'b1;

    check("pulse_latency", lat_bad, 0);
    check("pulse_exclusive", multi, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
